// File: rtl/axi_sram_wr_ctrl.sv
// AXI4 write-channel slave that turns each accepted W beat into one registered SRAM write.
// Handles FIXED/INCR/WRAP bursts, byte strobes, ID echo and a burst-level SLVERR response.
module axi_sram_wr_ctrl #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int ID_WIDTH   = 4,
  parameter int SRAM_AW    = 14,
  localparam int STRB_WIDTH = DATA_WIDTH / 8
) (
  input  logic                  ACLK,
  input  logic                  ARESET,
  input  logic [ID_WIDTH-1:0]   AWID,
  input  logic [ADDR_WIDTH-1:0] AWADDR,
  input  logic [7:0]            AWLEN,
  input  logic [2:0]            AWSIZE,
  input  logic [1:0]            AWBURST,
  input  logic                  AWVALID,
  output logic                  AWREADY,
  input  logic [DATA_WIDTH-1:0] WDATA,
  input  logic [STRB_WIDTH-1:0] WSTRB,
  input  logic                  WLAST,
  input  logic                  WVALID,
  output logic                  WREADY,
  output logic [ID_WIDTH-1:0]   BID,
  output logic [1:0]            BRESP,
  output logic                  BVALID,
  input  logic                  BREADY,
  output logic                  sram_we,
  output logic [SRAM_AW-1:0]    sram_addr,
  output logic [DATA_WIDTH-1:0] sram_wdata,
  output logic [STRB_WIDTH-1:0] sram_wstrb
);

  localparam int         OFS    = $clog2(STRB_WIDTH);
  localparam logic [2:0] OFS_SZ = 3'(OFS);

  typedef enum logic [1:0] {IDLE, DATA, RESP} state_t;
  state_t state, state_nx;

  logic [ID_WIDTH-1:0]   id_p0;
  logic [ADDR_WIDTH-1:0] addr_p0;
  logic [7:0]            len_p0;
  logic [2:0]            size_p0;
  logic [1:0]            burst_p0;
  logic [7:0]            cnt;
  logic                  cfg_err;
  logic                  last_err;
  logic                  aw_hs, w_hs, b_hs, last_beat, wlast_bad;

  // Bursts that cannot be mapped onto the bus are still drained but never written.
  function automatic logic cfg_bad(input logic [2:0] size, input logic [1:0] burst,
                                   input logic [7:0] len);
    logic wrap_len_ok;
    wrap_len_ok = (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
    return (size > OFS_SZ) || (burst == 2'b11) || ((burst == 2'b10) && !wrap_len_ok);
  endfunction

  function automatic logic [ADDR_WIDTH-1:0] addr_step(input logic [ADDR_WIDTH-1:0] a,
                                                       input logic [7:0] len,
                                                       input logic [2:0] size,
                                                       input logic [1:0] burst);
    logic [ADDR_WIDTH-1:0] s, m;
    s = ADDR_WIDTH'(1) << size;
    m = ((ADDR_WIDTH'(len) + ADDR_WIDTH'(1)) * s) - ADDR_WIDTH'(1);
    case (burst)
      2'b01:   return (a & ~(s - ADDR_WIDTH'(1))) + s;
      2'b10:   return (a & ~m) | ((a + s) & m);
      default: return a;
    endcase
  endfunction

  assign aw_hs     = AWVALID && AWREADY && (state == IDLE);
  assign w_hs      = WVALID && WREADY && (state == DATA);
  assign b_hs      = BVALID && BREADY;
  assign last_beat = (cnt == len_p0);
  assign wlast_bad = (WLAST != last_beat);

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (aw_hs) state_nx = DATA;
      DATA:    if (w_hs && last_beat) state_nx = RESP;
      RESP:    if (b_hs) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Stage p0: burst attributes captured on AW, address advanced per accepted beat
  always_ff @(posedge ACLK) begin
    if (aw_hs) begin
      id_p0    <= AWID;
      addr_p0  <= AWADDR;
      len_p0   <= AWLEN;
      size_p0  <= AWSIZE;
      burst_p0 <= AWBURST;
    end else if (w_hs) begin
      addr_p0 <= addr_step(addr_p0, len_p0, size_p0, burst_p0);
    end
  end

  // Stage p1: registered handshakes, SRAM write port and write response
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      AWREADY    <= 1'b0;
      WREADY     <= 1'b0;
      BVALID     <= 1'b0;
      BID        <= '0;
      BRESP      <= 2'b00;
      sram_we    <= 1'b0;
      sram_addr  <= '0;
      sram_wdata <= '0;
      sram_wstrb <= '0;
      cnt        <= 8'd0;
      cfg_err    <= 1'b0;
      last_err   <= 1'b0;
    end else begin
      AWREADY <= (state_nx == IDLE);
      WREADY  <= (state_nx == DATA);
      BVALID  <= (state_nx == RESP);
      sram_we <= w_hs && !cfg_err;
      if (aw_hs) begin
        cnt      <= 8'd0;
        cfg_err  <= cfg_bad(AWSIZE, AWBURST, AWLEN);
        last_err <= 1'b0;
      end
      if (w_hs) begin
        cnt        <= cnt + 8'd1;
        sram_addr  <= addr_p0[OFS+SRAM_AW-1:OFS];
        sram_wdata <= WDATA;
        sram_wstrb <= WSTRB;
        if (wlast_bad) last_err <= 1'b1;
        if (last_beat) begin
          BID   <= id_p0;
          BRESP <= (cfg_err || last_err || wlast_bad) ? 2'b10 : 2'b00;
        end
      end
    end
  end

endmodule

// File: tb/tb_axi_sram_wr_ctrl.sv
// Bench for axi_sram_wr_ctrl: directed burst scenarios plus randomized bursts
// checked against an address/response model computed from the burst rules.
module tb_axi_sram_wr_ctrl;
  localparam int DW = 32;
  localparam int AW = 32;
  localparam int IW = 4;
  localparam int SAW = 14;

  logic          ACLK = 1'b0;
  logic          ARESET = 1'b1;
  logic [IW-1:0] AWID = '0;
  logic [AW-1:0] AWADDR = '0;
  logic [7:0]    AWLEN = '0;
  logic [2:0]    AWSIZE = '0;
  logic [1:0]    AWBURST = '0;
  logic          AWVALID = 1'b0;
  logic          AWREADY;
  logic [DW-1:0] WDATA = '0;
  logic [3:0]    WSTRB = '0;
  logic          WLAST = 1'b0;
  logic          WVALID = 1'b0;
  logic          WREADY;
  logic [IW-1:0] BID;
  logic [1:0]    BRESP;
  logic          BVALID;
  logic          BREADY = 1'b0;
  logic          sram_we;
  logic [SAW-1:0] sram_addr;
  logic [DW-1:0] sram_wdata;
  logic [3:0]    sram_wstrb;

  int vectors = 0;
  int miscompares = 0;
  int we_count = 0;

  logic [DW-1:0]  b_data [256];
  logic [3:0]     b_strb [256];
  logic           b_last [256];
  logic           o_we   [256];
  logic [SAW-1:0] o_addr [256];
  logic [DW-1:0]  o_data [256];
  logic [3:0]     o_strb [256];
  logic [IW-1:0]  o_bid;
  logic [1:0]     o_bresp;
  logic           o_bvlat, o_awr_after, o_bv_after, o_stable, o_tmo;
  int             o_wecnt;

  axi_sram_wr_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ID_WIDTH(IW), .SRAM_AW(SAW)) dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .AWID(AWID), .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE), .AWBURST(AWBURST),
    .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST), .WVALID(WVALID), .WREADY(WREADY),
    .BID(BID), .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
    .sram_we(sram_we), .sram_addr(sram_addr), .sram_wdata(sram_wdata), .sram_wstrb(sram_wstrb)
  );

  always #5 ACLK = ~ACLK;

  always @(negedge ACLK) if (sram_we === 1'b1) we_count++;

  // Byte address of beat i, derived directly from the burst rules
  function automatic logic [31:0] model_addr(input logic [31:0] start, input int len,
                                             input int size, input int burst, input int i);
    logic [31:0] s, w, lower;
    s = 32'd1 << size;
    case (burst)
      1: model_addr = (i == 0) ? start : (start / s) * s + s * 32'(i);
      2: begin
        w = s * 32'(len + 1);
        lower = (start / w) * w;
        model_addr = lower + (((start - lower) + s * 32'(i)) % w);
      end
      default: model_addr = start;
    endcase
  endfunction

  function automatic bit model_cfg_err(input int size, input int burst, input int len);
    return (size > 2) || (burst == 3) ||
           ((burst == 2) && !(len == 1 || len == 3 || len == 7 || len == 15));
  endfunction

  task automatic fill_beats(input int len);
    for (int i = 0; i <= len; i++) begin
      b_data[i] = $urandom;
      b_strb[i] = 4'($urandom);
      b_last[i] = (i == len);
    end
  endtask

  task automatic do_burst(input logic [3:0] id, input logic [31:0] addr, input int len,
                          input int size, input int burst, input int hold, input bit gaps);
    int t, start_cnt;
    o_tmo = 1'b0;
    @(negedge ACLK);
    start_cnt = we_count;
    BREADY = (hold == 0);
    AWVALID = 1'b1; AWID = id; AWADDR = addr;
    AWLEN = 8'(len); AWSIZE = 3'(size); AWBURST = 2'(burst);
    t = 0;
    while (AWREADY !== 1'b1 && t < 20) begin @(negedge ACLK); t++; end
    if (t >= 20) o_tmo = 1'b1;
    @(posedge ACLK); @(negedge ACLK);
    AWVALID = 1'b0;
    for (int i = 0; i <= len; i++) begin
      if (gaps && $urandom_range(3) == 0) begin WVALID = 1'b0; @(negedge ACLK); end
      WVALID = 1'b1; WDATA = b_data[i]; WSTRB = b_strb[i]; WLAST = b_last[i];
      t = 0;
      while (WREADY !== 1'b1 && t < 20) begin @(negedge ACLK); t++; end
      if (t >= 20) o_tmo = 1'b1;
      @(posedge ACLK); @(negedge ACLK);
      o_we[i] = sram_we; o_addr[i] = sram_addr; o_data[i] = sram_wdata; o_strb[i] = sram_wstrb;
    end
    WVALID = 1'b0; WLAST = 1'b0;
    o_bvlat = BVALID;
    t = 0;
    while (BVALID !== 1'b1 && t < 20) begin @(negedge ACLK); t++; end
    if (t >= 20) o_tmo = 1'b1;
    o_bid = BID; o_bresp = BRESP; o_stable = 1'b1;
    if (hold > 0) begin
      AWVALID = 1'b1; AWID = ~id; AWADDR = $urandom;
      repeat (hold) begin
        @(negedge ACLK);
        if (BVALID !== 1'b1 || BID !== o_bid || BRESP !== o_bresp || AWREADY !== 1'b0 ||
            WREADY !== 1'b0) o_stable = 1'b0;
      end
      BREADY = 1'b1;
    end
    @(posedge ACLK); @(negedge ACLK);
    BREADY = 1'b0; AWVALID = 1'b0;
    o_awr_after = AWREADY; o_bv_after = BVALID;
    @(negedge ACLK);
    o_wecnt = we_count - start_cnt;
  endtask

  task automatic test_reset();
    ARESET = 1'b1;
    repeat (2) @(negedge ACLK);
    vectors++;
    if ({AWREADY, WREADY, BVALID, BRESP, BID, sram_we} !== '0) begin
      miscompares++;
      $display("FAIL reset_ctrl got %b want 0", {AWREADY, WREADY, BVALID, BRESP, BID, sram_we});
    end
    vectors++;
    if ({sram_addr, sram_wdata, sram_wstrb} !== '0) begin
      miscompares++;
      $display("FAIL reset_sram got %h/%h/%h want 0", sram_addr, sram_wdata, sram_wstrb);
    end
    ARESET = 1'b0;
    #1;
    vectors++;
    if (AWREADY !== 1'b0) begin
      miscompares++; $display("FAIL reset_awready_pre_edge got %b want 0", AWREADY);
    end
    @(negedge ACLK);
    vectors++;
    if (AWREADY !== 1'b1 || WREADY !== 1'b0) begin
      miscompares++; $display("FAIL reset_first_edge got awready=%b wready=%b want 1 0", AWREADY, WREADY);
    end
  endtask

  task automatic test_incr();
    logic [SAW-1:0] ea;
    fill_beats(3);
    for (int i = 0; i < 4; i++) b_strb[i] = 4'hF;
    do_burst(4'd5, 32'h100, 3, 2, 1, 0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      ea = SAW'(32'h40 + 32'(i));
      vectors++;
      if (o_we[i] !== 1'b1 || o_addr[i] !== ea || o_data[i] !== b_data[i] || o_strb[i] !== 4'hF) begin
        miscompares++;
        $display("FAIL incr_beat%0d got we=%b addr=%h data=%h strb=%h want we=1 addr=%h data=%h strb=f",
                 i, o_we[i], o_addr[i], o_data[i], o_strb[i], ea, b_data[i]);
      end
    end
    vectors++;
    if (o_bresp !== 2'b00 || o_bid !== 4'd5 || o_bvlat !== 1'b1) begin
      miscompares++;
      $display("FAIL incr_resp got bresp=%b bid=%0d bvlat=%b want 00 5 1", o_bresp, o_bid, o_bvlat);
    end
    vectors++;
    if (o_wecnt !== 4 || o_tmo !== 1'b0 || o_awr_after !== 1'b1 || o_bv_after !== 1'b0) begin
      miscompares++;
      $display("FAIL incr_done got wecnt=%0d tmo=%b awr=%b bv=%b want 4 0 1 0",
               o_wecnt, o_tmo, o_awr_after, o_bv_after);
    end
  endtask

  task automatic test_wrap();
    logic [SAW-1:0] ex [4];
    ex = '{14'h42, 14'h43, 14'h40, 14'h41};
    fill_beats(3);
    do_burst(4'd9, 32'h108, 3, 2, 2, 0, 1'b1);
    for (int i = 0; i < 4; i++) begin
      vectors++;
      if (o_we[i] !== 1'b1 || o_addr[i] !== ex[i] || o_strb[i] !== b_strb[i]) begin
        miscompares++;
        $display("FAIL wrap_beat%0d got we=%b addr=%h strb=%h want we=1 addr=%h strb=%h",
                 i, o_we[i], o_addr[i], o_strb[i], ex[i], b_strb[i]);
      end
    end
    vectors++;
    if (o_bresp !== 2'b00 || o_bid !== 4'd9 || o_wecnt !== 4) begin
      miscompares++;
      $display("FAIL wrap_resp got bresp=%b bid=%0d wecnt=%0d want 00 9 4", o_bresp, o_bid, o_wecnt);
    end
  endtask

  task automatic test_fixed();
    fill_beats(2);
    for (int i = 0; i < 3; i++) b_strb[i] = 4'(1 << i);
    do_burst(4'd1, 32'h20, 2, 2, 0, 0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      vectors++;
      if (o_we[i] !== 1'b1 || o_addr[i] !== 14'h08 || o_strb[i] !== 4'(1 << i) ||
          o_data[i] !== b_data[i]) begin
        miscompares++;
        $display("FAIL fixed_beat%0d got we=%b addr=%h strb=%h want we=1 addr=008 strb=%h",
                 i, o_we[i], o_addr[i], o_strb[i], 4'(1 << i));
      end
    end
    vectors++;
    if (o_bresp !== 2'b00 || o_wecnt !== 3) begin
      miscompares++; $display("FAIL fixed_resp got bresp=%b wecnt=%0d want 00 3", o_bresp, o_wecnt);
    end
  endtask

  task automatic test_errors();
    fill_beats(1);
    do_burst(4'd2, 32'h40, 1, 3, 1, 0, 1'b0);
    vectors++;
    if (o_we[0] !== 1'b0 || o_we[1] !== 1'b0 || o_wecnt !== 0 || o_tmo !== 1'b0) begin
      miscompares++;
      $display("FAIL err_size got we=%b%b wecnt=%0d tmo=%b want 00 0 0", o_we[0], o_we[1], o_wecnt, o_tmo);
    end
    vectors++;
    if (o_bresp !== 2'b10 || o_bid !== 4'd2) begin
      miscompares++; $display("FAIL err_size_resp got bresp=%b bid=%0d want 10 2", o_bresp, o_bid);
    end
    fill_beats(3);
    for (int i = 0; i < 4; i++) b_last[i] = (i == 1);
    do_burst(4'd7, 32'h80, 3, 2, 1, 0, 1'b0);
    vectors++;
    if (o_wecnt !== 4 || o_bresp !== 2'b10 || o_tmo !== 1'b0) begin
      miscompares++;
      $display("FAIL err_wlast got wecnt=%0d bresp=%b tmo=%b want 4 10 0", o_wecnt, o_bresp, o_tmo);
    end
    fill_beats(2);
    do_burst(4'd3, 32'h80, 2, 2, 3, 0, 1'b0);
    vectors++;
    if (o_wecnt !== 0 || o_bresp !== 2'b10) begin
      miscompares++; $display("FAIL err_reserved got wecnt=%0d bresp=%b want 0 10", o_wecnt, o_bresp);
    end
  endtask

  task automatic test_back_to_back();
    fill_beats(1);
    do_burst(4'd12, 32'h300, 1, 2, 1, 5, 1'b0);
    vectors++;
    if (o_stable !== 1'b1 || o_bresp !== 2'b00 || o_bid !== 4'd12) begin
      miscompares++;
      $display("FAIL bp_hold got stable=%b bresp=%b bid=%0d want 1 00 12", o_stable, o_bresp, o_bid);
    end
    vectors++;
    if (o_awr_after !== 1'b1 || o_bv_after !== 1'b0 || o_wecnt !== 2) begin
      miscompares++;
      $display("FAIL bp_release got awr=%b bv=%b wecnt=%0d want 1 0 2", o_awr_after, o_bv_after, o_wecnt);
    end
    fill_beats(0);
    do_burst(4'd4, 32'h44, 0, 2, 0, 0, 1'b0);
    vectors++;
    if (o_we[0] !== 1'b1 || o_addr[0] !== 14'h11 || o_bid !== 4'd4 || o_bresp !== 2'b00) begin
      miscompares++;
      $display("FAIL b2b_next got we=%b addr=%h bid=%0d bresp=%b want 1 011 4 00",
               o_we[0], o_addr[0], o_bid, o_bresp);
    end
  endtask

  task automatic test_reset_mid_burst();
    int t, c0;
    @(negedge ACLK);
    AWVALID = 1'b1; AWID = 4'd6; AWADDR = 32'h200; AWLEN = 8'd7; AWSIZE = 3'd2; AWBURST = 2'd1;
    t = 0;
    while (AWREADY !== 1'b1 && t < 20) begin @(negedge ACLK); t++; end
    @(posedge ACLK); @(negedge ACLK);
    AWVALID = 1'b0;
    for (int i = 0; i < 2; i++) begin
      WVALID = 1'b1; WDATA = $urandom; WSTRB = 4'hF; WLAST = 1'b0;
      t = 0;
      while (WREADY !== 1'b1 && t < 20) begin @(negedge ACLK); t++; end
      @(posedge ACLK); @(negedge ACLK);
    end
    vectors++;
    if (sram_we !== 1'b1 || sram_addr !== 14'h81) begin
      miscompares++; $display("FAIL rst_mid_pre got we=%b addr=%h want 1 081", sram_we, sram_addr);
    end
    #1 ARESET = 1'b1;
    #1;
    vectors++;
    if ({AWREADY, WREADY, BVALID, BRESP, BID, sram_we} !== '0 ||
        {sram_addr, sram_wdata, sram_wstrb} !== '0) begin
      miscompares++;
      $display("FAIL rst_mid_outputs got ctrl=%b addr=%h data=%h strb=%h want 0",
               {AWREADY, WREADY, BVALID, BRESP, BID, sram_we}, sram_addr, sram_wdata, sram_wstrb);
    end
    c0 = we_count;
    repeat (2) @(negedge ACLK);
    ARESET = 1'b0;
    @(negedge ACLK);
    vectors++;
    if (AWREADY !== 1'b1 || WREADY !== 1'b0) begin
      miscompares++; $display("FAIL rst_mid_release got awready=%b wready=%b want 1 0", AWREADY, WREADY);
    end
    repeat (4) @(negedge ACLK);
    WVALID = 1'b0;
    vectors++;
    if (we_count !== c0 || WREADY !== 1'b0) begin
      miscompares++; $display("FAIL rst_mid_no_we got writes=%0d wready=%b want 0 0", we_count - c0, WREADY);
    end
  endtask

  task automatic test_random();
    int len, size, burst, r, hold;
    logic [3:0] id;
    logic [31:0] start, ea;
    bit ce, le;
    for (int b = 0; b < 40; b++) begin
      r = $urandom_range(9);
      burst = (r < 2) ? 0 : (r < 6) ? 1 : (r < 9) ? 2 : 3;
      size = ($urandom_range(9) == 0) ? 3 : $urandom_range(2);
      if (burst == 2) len = ($urandom_range(7) == 0) ? 2 : (2 << $urandom_range(3)) - 1;
      else len = $urandom_range(15);
      start = $urandom;
      if ($urandom_range(4) == 0) start = 32'hFFFF_FFF0 | ($urandom & 32'hF);
      id = 4'($urandom);
      hold = $urandom_range(3);
      fill_beats(len);
      if ($urandom_range(5) == 0) begin
        r = $urandom_range(len);
        b_last[r] = ~b_last[r];
      end
      ce = model_cfg_err(size, burst, len);
      le = 1'b0;
      for (int i = 0; i <= len; i++) if (b_last[i] != (i == len)) le = 1'b1;
      do_burst(id, start, len, size, burst, hold, 1'b1);
      for (int i = 0; i <= len; i++) begin
        vectors++;
        if (o_we[i] !== !ce) begin
          miscompares++;
          $display("FAIL rnd%0d_we%0d got %b want %b", b, i, o_we[i], !ce);
        end else if (!ce) begin
          ea = model_addr(start, len, size, burst, i);
          vectors++;
          if (o_addr[i] !== ea[15:2] || o_data[i] !== b_data[i] || o_strb[i] !== b_strb[i]) begin
            miscompares++;
            $display("FAIL rnd%0d_beat%0d got addr=%h data=%h strb=%h want addr=%h data=%h strb=%h",
                     b, i, o_addr[i], o_data[i], o_strb[i], ea[15:2], b_data[i], b_strb[i]);
          end
        end
      end
      vectors++;
      if (o_bresp !== ((ce || le) ? 2'b10 : 2'b00) || o_bid !== id || o_bvlat !== 1'b1 ||
          o_stable !== 1'b1) begin
        miscompares++;
        $display("FAIL rnd%0d_resp got bresp=%b bid=%0d bvlat=%b stable=%b want %b %0d 1 1",
                 b, o_bresp, o_bid, o_bvlat, o_stable, (ce || le) ? 2'b10 : 2'b00, id);
      end
      vectors++;
      if (o_wecnt !== (ce ? 0 : len + 1) || o_tmo !== 1'b0 || o_awr_after !== 1'b1) begin
        miscompares++;
        $display("FAIL rnd%0d_count got wecnt=%0d tmo=%b awr=%b want %0d 0 1",
                 b, o_wecnt, o_tmo, o_awr_after, ce ? 0 : len + 1);
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog simulation did not complete");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_incr();
    test_wrap();
    test_fixed();
    test_errors();
    test_back_to_back();
    test_reset_mid_burst();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
